// File: rtl/codon_seq_ctrl_pkg.sv
// Shared types and constants for the codon pattern sequencer.
// A pattern is six 4-bit codons, nibble 5 first, padded with CODON_TERM.
package codon_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef logic [3:0]  codon_t;
    typedef codon_t [5:0] pattern_t;

    localparam codon_t CODON_TERM = 4'hF;
    localparam int     NUM_PAT    = 6;
    localparam int     WDOG_CYC   = 260;

    // Empty table entry: every codon slot holds the terminator.
    function automatic pattern_t pattern_blank();
        return {6{CODON_TERM}};
    endfunction

endpackage

// File: rtl/codon_seq_ctrl_if.sv
// Handshake between the sequencer (master) and the codon counter (slave).
interface codon_seq_ctrl_if;
    import codon_seq_ctrl_pkg::*;

    logic     init_cnt_ena;
    logic     count_ena;
    pattern_t data;
    logic     done_gen;
    pattern_t reg_cnt_cod;

    modport master (
        output init_cnt_ena,
        output count_ena,
        output data,
        input  done_gen,
        input  reg_cnt_cod
    );

    modport slave (
        input  init_cnt_ena,
        input  count_ena,
        input  data,
        output done_gen,
        output reg_cnt_cod
    );

endinterface

// File: rtl/codon_pat_table.sv
// Pattern table: registered write port, asynchronous read port.
// Out-of-range writes are dropped; out-of-range reads return a blank pattern.
module codon_pat_table
    import codon_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = codon_seq_ctrl_pkg::NUM_PAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  pattern_t   wr_data,
    input  logic [2:0] rd_idx,
    output pattern_t   rd_data
);

    pattern_t mem_r [DEPTH];

    // Table storage, cleared to blank patterns on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= pattern_blank();
            end
        end else if (wr_en && (32'(wr_idx) < DEPTH)) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Asynchronous read of the entry selected by the current pass.
    always_comb begin
        rd_data = pattern_blank();
        if (32'(rd_idx) < DEPTH) begin
            rd_data = mem_r[rd_idx];
        end else begin
            rd_data = pattern_blank();
        end
    end

endmodule

// File: rtl/codon_seq_ctrl.sv
// Codon sequencer: walks NUM_PAT table patterns through the codon counter,
// one INIT/RUN/NEXT pass each, with a per-pass watchdog and abort.
module codon_seq_ctrl
    import codon_seq_ctrl_pkg::*;
#(
    parameter int NUM_PAT  = codon_seq_ctrl_pkg::NUM_PAT,
    parameter int WDOG_CYC = codon_seq_ctrl_pkg::WDOG_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    pat_wr_en,
    input  logic [2:0]              pat_wr_idx,
    input  pattern_t                pat_wr_data,
    codon_seq_ctrl_if.master        cnt,
    output logic [2:0]              pass_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output pattern_t                results
);

    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    state_t              state_r, state_nxt_s;
    logic [2:0]          pass_r, pass_nxt_s;
    logic [WDOG_W-1:0]   wdog_r, wdog_nxt_s;
    logic                err_r, err_nxt_s;
    pattern_t            results_r, results_nxt_s;
    logic                tbl_we_s;
    pattern_t            tbl_rd_s;
    logic                init_cnt_ena_r, count_ena_r, busy_r, done_r;

    codon_pat_table #(.DEPTH(NUM_PAT)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tbl_we_s),
        .wr_idx  (pat_wr_idx),
        .wr_data (pat_wr_data),
        .rd_idx  (pass_r),
        .rd_data (tbl_rd_s)
    );

    // Next-state logic; abort overrides start, done_gen and the watchdog.
    always_comb begin
        state_nxt_s   = state_r;
        pass_nxt_s    = pass_r;
        wdog_nxt_s    = wdog_r;
        err_nxt_s     = err_r;
        results_nxt_s = results_r;
        tbl_we_s      = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tbl_we_s = pat_wr_en;
                    if (start) begin
                        state_nxt_s = ST_INIT;
                        pass_nxt_s  = 3'd0;
                        err_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    wdog_nxt_s  = {WDOG_W{1'b0}};
                    state_nxt_s = ST_RUN;
                end
                ST_RUN: begin
                    wdog_nxt_s = wdog_r + WDOG_W'(1);
                    // done_gen on the expiry cycle still counts as a clean pass.
                    if (cnt.done_gen) begin
                        state_nxt_s = ST_NEXT;
                    end else if (wdog_r == WDOG_W'(WDOG_CYC - 1)) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_NEXT: begin
                    results_nxt_s[pass_r] = cnt.reg_cnt_cod[pass_r];
                    if (pass_r == 3'(NUM_PAT - 1)) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        pass_nxt_s  = pass_r + 3'd1;
                        state_nxt_s = ST_INIT;
                    end
                end
                ST_FINISH: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            pass_r         <= 3'd0;
            wdog_r         <= {WDOG_W{1'b0}};
            err_r          <= 1'b0;
            results_r      <= {24{1'b0}};
            init_cnt_ena_r <= 1'b0;
            count_ena_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pass_r         <= pass_nxt_s;
            wdog_r         <= wdog_nxt_s;
            err_r          <= err_nxt_s;
            results_r      <= results_nxt_s;
            init_cnt_ena_r <= (state_nxt_s == ST_INIT);
            count_ena_r    <= (state_nxt_s == ST_RUN);
            busy_r         <= (state_nxt_s != ST_IDLE);
            done_r         <= (state_nxt_s == ST_FINISH);
        end
    end

    assign cnt.init_cnt_ena = init_cnt_ena_r;
    assign cnt.count_ena    = count_ena_r;
    assign cnt.data         = tbl_rd_s;
    assign pass_idx         = pass_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;
    assign results          = results_r;

endmodule

// File: tb/tb_codon_seq_ctrl.sv
// Bench for codon_seq_ctrl: behavioural codon counter plus INIT-data scoreboard.
module tb_codon_seq_ctrl;
    import codon_seq_ctrl_pkg::*;

    logic       clk, rst, start, abort, pat_wr_en;
    logic [2:0] pat_wr_idx;
    pattern_t   pat_wr_data;
    logic [2:0] pass_idx;
    logic       busy, done, err;
    pattern_t   results;

    codon_seq_ctrl_if cif ();

    codon_seq_ctrl #(.NUM_PAT(NUM_PAT), .WDOG_CYC(WDOG_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx), .pat_wr_data(pat_wr_data),
        .cnt(cif.master), .pass_idx(pass_idx), .busy(busy), .done(done),
        .err(err), .results(results)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          gen_delay = 10;
    int          gen_stall = -1;
    pattern_t    gen_counts = 24'h000000;
    logic        model_dg = 1'b0;
    logic        force_dg = 1'b0;
    pattern_t    model_cnt = 24'h000000;
    int          run_cnt = 0, last_run = 0, init_pulses = 0, done_pulses = 0, data_glitch = 0;
    pattern_t    cur_data = 24'hFFFFFF;
    logic [26:0] obs_q [$];
    logic [26:0] exp_q [$];
    pattern_t    shadow [6];
    pattern_t    exp_results;

    assign cif.done_gen    = model_dg | force_dg;
    assign cif.reg_cnt_cod = model_cnt;

    // Codon counter model: raises done_gen on RUN cycle gen_delay and posts its count.
    always @(negedge clk) begin
        if (!rst) begin
            model_dg  = 1'b0;
            run_cnt   = 0;
            model_cnt = 24'h000000;
        end else begin
            if (done) done_pulses++;
            if (cif.init_cnt_ena) begin
                init_pulses++;
                obs_q.push_back({pass_idx, cif.data});
                cur_data  = cif.data;
                model_cnt = 24'h000000;
            end
            if (cif.count_ena) begin
                run_cnt++;
                if (cif.data !== cur_data) data_glitch++;
                model_dg = (run_cnt == gen_delay) && (int'(pass_idx) != gen_stall);
                if (model_dg) model_cnt[pass_idx] = gen_counts[pass_idx];
            end else begin
                if (run_cnt > 0) last_run = run_cnt;
                run_cnt  = 0;
                model_dg = 1'b0;
            end
        end
    end

    task automatic write_pat(input logic [2:0] idx, input pattern_t val);
        @(negedge clk);
        pat_wr_en = 1'b1; pat_wr_idx = idx; pat_wr_data = val;
        @(negedge clk);
        pat_wr_en = 1'b0;
    endtask

    task automatic start_run(input int npass);
        for (int k = 0; k < npass; k++) exp_q.push_back({3'(k), shadow[k]});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int busy_cyc);
        busy_cyc = 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; pat_wr_en = 1'b0;
        pat_wr_idx = 3'd0; pat_wr_data = 24'h000000; force_dg = 1'b0;
        for (int i = 0; i < 6; i++) shadow[i] = 24'hFFFFFF;
        exp_results = 24'h000000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        checks++; if ({cif.init_cnt_ena, cif.count_ena} !== 2'b00) begin errors++; $display("FAIL reset_ena got %b exp 00", {cif.init_cnt_ena, cif.count_ena}); end
        checks++; if (pass_idx !== 3'd0) begin errors++; $display("FAIL reset_pass got %0d exp 0", pass_idx); end
        checks++; if (results !== 24'h000000) begin errors++; $display("FAIL reset_results got %h exp 000000", results); end
        checks++; if (cif.data !== 24'hFFFFFF) begin errors++; $display("FAIL reset_data got %h exp ffffff", cif.data); end
    endtask

    task automatic test_full_run();
        pattern_t pats [6] = '{24'h123FFF, 24'h321FFF, 24'h0A3FFF, 24'h3210FF, 24'h2FFFFF, 24'h01233F};
        int ob, d0, i0, g0, bc;
        logic [26:0] e, o;
        for (int i = 0; i < 6; i++) begin write_pat(3'(i), pats[i]); shadow[i] = pats[i]; end
        checks++; if (cif.data !== shadow[0]) begin errors++; $display("FAIL idle_data got %h exp %h", cif.data, shadow[0]); end
        gen_delay = 10; gen_stall = -1; gen_counts = 24'h654321;
        ob = obs_q.size(); d0 = done_pulses; i0 = init_pulses; g0 = data_glitch;
        start_run(6);
        wait_idle(200, bc);
        exp_results = 24'h654321;
        checks++; if (bc !== 73) begin errors++; $display("FAIL run_latency got %0d exp 73", bc); end
        checks++; if (init_pulses - i0 !== 6) begin errors++; $display("FAIL run_inits got %0d exp 6", init_pulses - i0); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL run_done got %0d exp 1", done_pulses - d0); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL run_results got %h exp %h", results, exp_results); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL run_err got %0b exp 0", err); end
        checks++; if (data_glitch - g0 !== 0) begin errors++; $display("FAIL run_data_stable got %0d exp 0", data_glitch - g0); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            o = (ob + k < obs_q.size()) ? obs_q[ob + k] : 27'h0;
            checks++; if (o !== e) begin errors++; $display("FAIL run_init_data%0d got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_watchdog();
        int ob, d0, bc;
        logic [26:0] e, o;
        gen_delay = 10; gen_stall = 2; gen_counts = 24'hABCDEF;
        ob = obs_q.size(); d0 = done_pulses;
        start_run(3);
        wait_idle(400, bc);
        exp_results[0] = 4'hF; exp_results[1] = 4'hE;
        checks++; if (bc !== 285) begin errors++; $display("FAIL wdog_latency got %0d exp 285", bc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdog_err got %0b exp 1", err); end
        checks++; if (done_pulses - d0 !== 0) begin errors++; $display("FAIL wdog_done got %0d exp 0", done_pulses - d0); end
        checks++; if (last_run !== WDOG_CYC) begin errors++; $display("FAIL wdog_run_len got %0d exp %0d", last_run, WDOG_CYC); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL wdog_results got %h exp %h", results, exp_results); end
        checks++; if (obs_q.size() - ob !== 3) begin errors++; $display("FAIL wdog_inits got %0d exp 3", obs_q.size() - ob); end
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            o = (ob + k < obs_q.size()) ? obs_q[ob + k] : 27'h0;
            checks++; if (o !== e) begin errors++; $display("FAIL wdog_init_data%0d got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_wdog_tie();
        int d0, bc;
        gen_delay = WDOG_CYC; gen_stall = -1; gen_counts = 24'h2468AC;
        d0 = done_pulses;
        start_run(0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tie_err_cleared got %0b exp 0", err); end
        wait_idle(2000, bc);
        exp_results = 24'h2468AC;
        checks++; if (bc !== 1573) begin errors++; $display("FAIL tie_latency got %0d exp 1573", bc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tie_err got %0b exp 0", err); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL tie_done got %0d exp 1", done_pulses - d0); end
        checks++; if (last_run !== WDOG_CYC) begin errors++; $display("FAIL tie_run_len got %0d exp %0d", last_run, WDOG_CYC); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL tie_results got %h exp %h", results, exp_results); end
    endtask

    task automatic test_abort();
        int d0, i0, rc;
        gen_delay = 10; gen_stall = -1; gen_counts = 24'h13579B;
        d0 = done_pulses; i0 = init_pulses; rc = 0;
        start_run(0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cif.count_ena && (pass_idx == 3'd4)) rc++;
            if (rc == 3) break;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_results = 24'h24579B;
        checks++; if (rc !== 3) begin errors++; $display("FAIL abort_reach got %0d exp 3", rc); end
        checks++; if ({cif.init_cnt_ena, cif.count_ena} !== 2'b00) begin errors++; $display("FAIL abort_ena got %b exp 00", {cif.init_cnt_ena, cif.count_ena}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL abort_results got %h exp %h", results, exp_results); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err got %0b exp 0", err); end
        repeat (3) @(negedge clk);
        checks++; if (done_pulses - d0 !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_pulses - d0); end
        checks++; if (init_pulses - i0 !== 5) begin errors++; $display("FAIL abort_inits got %0d exp 5", init_pulses - i0); end
    endtask

    task automatic test_busy_writes();
        int ob, d0, bc;
        logic [26:0] e, o;
        gen_delay = 5; gen_stall = -1; gen_counts = 24'h654321;
        ob = obs_q.size(); d0 = done_pulses;
        start_run(6);
        write_pat(3'd2, 24'h111111);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(200, bc);
        write_pat(3'd7, 24'h000000);
        shadow[0] = 24'h3300FF;
        for (int k = 0; k < 6; k++) exp_q.push_back({3'(k), shadow[k]});
        @(negedge clk);
        pat_wr_en = 1'b1; pat_wr_idx = 3'd0; pat_wr_data = 24'h3300FF; start = 1'b1;
        @(negedge clk);
        pat_wr_en = 1'b0; start = 1'b0;
        wait_idle(200, bc);
        exp_results = 24'h654321;
        checks++; if (bc !== 43) begin errors++; $display("FAIL wr_latency got %0d exp 43", bc); end
        checks++; if (done_pulses - d0 !== 2) begin errors++; $display("FAIL wr_done got %0d exp 2", done_pulses - d0); end
        checks++; if (obs_q.size() - ob !== 12) begin errors++; $display("FAIL wr_inits got %0d exp 12", obs_q.size() - ob); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL wr_results got %h exp %h", results, exp_results); end
        for (int k = 0; k < 12; k++) begin
            e = exp_q.pop_front();
            o = (ob + k < obs_q.size()) ? obs_q[ob + k] : 27'h0;
            checks++; if (o !== e) begin errors++; $display("FAIL wr_init_data%0d got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_done_gen_idle();
        @(negedge clk); force_dg = 1'b1;
        @(negedge clk); force_dg = 1'b0;
        @(negedge clk);
        checks++; if ({busy, cif.count_ena} !== 2'b00) begin errors++; $display("FAIL dg_idle_state got %b exp 00", {busy, cif.count_ena}); end
        checks++; if (results !== exp_results) begin errors++; $display("FAIL dg_idle_results got %h exp %h", results, exp_results); end
    endtask

    task automatic test_reset_mid_run();
        int d0, rc, ob, bc;
        logic [26:0] e, o;
        gen_delay = 10; gen_stall = -1; gen_counts = 24'h999999;
        d0 = done_pulses; rc = 0;
        start_run(0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cif.count_ena && (pass_idx == 3'd3)) rc++;
            if (rc == 2) break;
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (rc !== 2) begin errors++; $display("FAIL rst_reach got %0d exp 2", rc); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
        checks++; if ({cif.init_cnt_ena, cif.count_ena} !== 2'b00) begin errors++; $display("FAIL rst_ena got %b exp 00", {cif.init_cnt_ena, cif.count_ena}); end
        checks++; if (pass_idx !== 3'd0) begin errors++; $display("FAIL rst_pass got %0d exp 0", pass_idx); end
        checks++; if (results !== 24'h000000) begin errors++; $display("FAIL rst_results got %h exp 000000", results); end
        checks++; if (cif.data !== 24'hFFFFFF) begin errors++; $display("FAIL rst_data got %h exp ffffff", cif.data); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) shadow[i] = 24'hFFFFFF;
        gen_delay = 2; gen_counts = 24'h654321;
        ob = obs_q.size();
        start_run(6);
        wait_idle(100, bc);
        checks++; if (bc !== 25) begin errors++; $display("FAIL rst_rerun_latency got %0d exp 25", bc); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL rst_done got %0d exp 1", done_pulses - d0); end
        checks++; if (results !== 24'h654321) begin errors++; $display("FAIL rst_rerun_results got %h exp 654321", results); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            o = (ob + k < obs_q.size()) ? obs_q[ob + k] : 27'h0;
            checks++; if (o !== e) begin errors++; $display("FAIL rst_table%0d got %h exp %h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_watchdog();
        test_wdog_tie();
        test_abort();
        test_busy_writes();
        test_done_gen_idle();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
